mul_acc_seq: RTL and testbench
==============================

# mul_acc_seq

Sequential multiply-accumulate front end for MulAddUns: consumes a valid/ready stream of (X, Y) operand pairs grouped into sequences by a last flag and holds the running sum in an accumulator register fed back as MulAddUns augend A. On the last beat of a sequence it registers the final dot product, beat count and overflow flag behind an output valid/ready handshake, then clears the accumulator. It sits between operand-fetch logic and result consumers in the LAU datapath.

## Interface
- widthX, 8, multiplier width (<= widthY)
- widthY, 8, multiplicand width
- widthA, 20, accumulator/result width (>= widthX+widthY)
- widthCnt, 16, beat-counter width
- speed, lau_pkg::FAST, performance parameter passed to MulAddUns
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  operand beat accepted when in_valid_i && in_ready_o
- X_i  in  widthX  multiplier operand
- Y_i  in  widthY  multiplicand operand
- last_i  in  1  beat closes current sequence
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- P_o  out  widthA  accumulated sum mod 2^widthA
- count_o  out  widthCnt  beats in sequence, saturating at 2^widthCnt-1
- ovf_o  out  1  sticky: at least one wrap occurred in sequence

## Operation
- States (lau_pkg::macc_state_e): IDLE (no beats, acc=0), ACC (partial sum held), DONE (result held, out_valid_o=1).
- Combinational sum = MulAddUns(X_i, Y_i, acc); wrap on beat iff sum < acc.
- in_ready_o = !out_valid_o || out_ready_i (combinational from out_ready_i; no skid buffer).
- Accepted beat, last_i=0: acc <= sum; cnt <= sat(cnt+1); ovfAcc <= ovfAcc | wrap; -> ACC.
- Accepted beat, last_i=1: P_o <= sum, count_o <= sat(cnt+1), ovf_o <= ovfAcc | wrap; acc, cnt, ovfAcc <= 0; -> DONE.
- DONE: outputs held stable while out_ready_i=0. Output pop without beat -> IDLE. Pop with non-last beat -> ACC. Pop with last beat -> DONE with new result (back-to-back).
- IDLE/ACC never assert out_valid_o; output registers hold last value but are don't-care.
- Counter saturates at all-ones; accumulator wraps modulo 2^widthA.
- Reset: state IDLE; acc, cnt, ovfAcc, P_o, count_o, ovf_o, out_valid_o = 0; in_ready_o=1 after reset. Reset mid-sequence discards the partial sum without emitting a result.

## Timing
- One beat per cycle sustained, including across sequence boundaries when out_ready_i=1.
- Latency: out_valid_o rises the cycle after the last-beat handshake.
- Critical path: acc register -> MulAddUns -> acc register; no internal pipelining.
- No combinational path from in_valid_i to out_valid_o; only out_ready_i -> in_ready_o is combinational.

## Structure
- lau_pkg: add macc_state_e {IDLE, ACC, DONE}; reuse speed_e.
- Single sub-module: MulAddUns #(widthX, widthY, widthA, speed), A driven by acc.
- Elaboration assertions: widthX <= widthY, widthA >= widthX+widthY, widthCnt >= 1.

## Test plan
- Beats (3,4),(5,6),(7,8,last), out_ready_i=1 -> next cycle out_valid_o=1, P_o=98, count_o=3, ovf_o=0; state IDLE one cycle later.
- Single beat (255,255,last) -> P_o=65025, count_o=1, ovf_o=0.
- 17 beats of (255,255), last on 17th -> P_o=56849 (1105425 mod 2^20), count_o=17, ovf_o=1; next sequence (1,1,last) -> P_o=1, ovf_o=0.
- Result pending, out_ready_i=0 for 5 cycles with in_valid_i=1 -> in_ready_o=0, P_o/count_o stable; out_ready_i rises -> pop and beat (2,2,last) accepted same cycle, next P_o=4.
- rst_ni pulled low after 2 accepted beats (10,10),(10,10) -> all outputs 0 asynchronously; after release (2,3,last) -> P_o=6, count_o=1.
- Back-to-back single-beat sequences (i,i,last) for i=1..4, in_valid_i=out_ready_i=1 continuously -> in_ready_o stays 1, P_o=1,4,9,16 on four consecutive cycles.

Source files
------------

// File: rtl/lau_pkg.sv
// lau_pkg: shared types for the LAU datapath.
//   speed_e      - implementation choice for arithmetic blocks (FAST: direct
//                  multiplier, SLOW: unrolled shift-add array).
//   macc_state_e - control state of the sequential multiply-accumulate front end.
package lau_pkg;

    typedef enum logic {
        FAST,
        SLOW
    } speed_e;

    typedef enum logic [1:0] {
        IDLE,  // current sequence empty, accumulator is zero
        ACC,   // partial sum held in accumulator
        DONE   // result registered, out_valid_o asserted
    } macc_state_e;

endpackage

// File: rtl/MulAddUns.sv
// MulAddUns: unsigned combinational multiply-add, P_o = X_i * Y_i + A_i mod 2^widthA.
//   X_i  widthX  multiplier
//   Y_i  widthY  multiplicand
//   A_i  widthA  augend
//   P_o  widthA  result, wraps modulo 2^widthA
// The product alone always fits in widthA bits; only the final add can wrap.
module MulAddUns
    import lau_pkg::*;
#(
    parameter int unsigned widthX = 8,
    parameter int unsigned widthY = 8,
    parameter int unsigned widthA = 20,
    parameter speed_e      speed  = FAST
) (
    input  logic [widthX-1:0] X_i,
    input  logic [widthY-1:0] Y_i,
    input  logic [widthA-1:0] A_i,
    output logic [widthA-1:0] P_o
);

    logic [widthA-1:0] prod;

    if (speed == FAST) begin : g_fast
        assign prod = widthA'(X_i) * widthA'(Y_i);
    end else begin : g_slow
        // Shift-add array, one partial product per multiplier bit.
        always_comb begin
            prod = '0;
            for (int i = 0; i < int'(widthX); i++) begin
                if (X_i[i]) begin
                    prod = prod + (widthA'(Y_i) << i);
                end
            end
        end
    end

    assign P_o = prod + A_i;

endmodule

// File: rtl/mul_acc_seq.sv
// mul_acc_seq: sequential multiply-accumulate front end for MulAddUns.
// Consumes (X, Y) beats grouped by last_i, accumulates X*Y, and on the last
// beat registers the dot product, beat count and wrap flag behind an output
// valid/ready handshake.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  operand beat handshake
//   X_i, Y_i, last_i       operands and end-of-sequence flag
//   out_valid_o/out_ready_i result handshake
//   P_o                    accumulated sum mod 2^widthA
//   count_o                beats in sequence, saturating
//   ovf_o                  at least one accumulator wrap occurred in sequence
module mul_acc_seq
    import lau_pkg::*;
#(
    parameter int unsigned widthX   = 8,
    parameter int unsigned widthY   = 8,
    parameter int unsigned widthA   = 20,
    parameter int unsigned widthCnt = 16,
    parameter speed_e      speed    = FAST
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [widthX-1:0]   X_i,
    input  logic [widthY-1:0]   Y_i,
    input  logic                last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [widthA-1:0]   P_o,
    output logic [widthCnt-1:0] count_o,
    output logic                ovf_o
);

    if (widthX > widthY) begin : g_chk_xy
        $error("mul_acc_seq: widthX must not exceed widthY");
    end
    if (widthA < widthX + widthY) begin : g_chk_a
        $error("mul_acc_seq: widthA must hold the full product");
    end
    if (widthCnt < 1) begin : g_chk_cnt
        $error("mul_acc_seq: widthCnt must be at least 1");
    end

    macc_state_e         state_q, state_d;
    logic [widthA-1:0]   acc_q, acc_d;
    logic [widthCnt-1:0] cnt_q, cnt_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [widthA-1:0]   p_q, p_d;
    logic [widthCnt-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;

    logic [widthA-1:0]   sum;
    logic [widthCnt-1:0] cnt_inc;
    logic                wrap;
    logic                in_fire;
    logic                out_valid;

    MulAddUns #(
        .widthX (widthX),
        .widthY (widthY),
        .widthA (widthA),
        .speed  (speed)
    ) u_mul_add (
        .X_i (X_i),
        .Y_i (Y_i),
        .A_i (acc_q),
        .P_o (sum)
    );

    // Product fits in widthA bits, so the add wrapped iff the sum fell below acc.
    assign wrap    = (sum < acc_q);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + widthCnt'(1);

    assign out_valid = (state_q == DONE);
    // A pending result blocks new beats unless it is popped in the same cycle.
    assign in_ready_o = !out_valid || out_ready_i;
    assign in_fire    = in_valid_i && in_ready_o;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        p_d       = p_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (in_fire) begin
            if (last_i) begin
                p_d       = sum;
                count_d   = cnt_inc;
                ovf_d     = ovf_acc_q | wrap;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_acc_d = 1'b0;
                state_d   = DONE;
            end else begin
                acc_d     = sum;
                cnt_d     = cnt_inc;
                ovf_acc_d = ovf_acc_q | wrap;
                state_d   = ACC;
            end
        end else if (out_valid && out_ready_i) begin
            // Pop with no beat: accumulator was already cleared on the last beat.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            p_q       <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            p_q       <= p_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid_o = out_valid;
    assign P_o         = p_q;
    assign count_o     = count_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_mul_acc_seq.sv
// Directed self-checking bench for mul_acc_seq (default parameters).
module tb_mul_acc_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  X_i = '0;
    logic [7:0]  Y_i = '0;
    logic        last_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [19:0] P_o;
    logic [15:0] count_o;
    logic        ovf_o;

    int checks = 0;
    int failures = 0;

    mul_acc_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .X_i         (X_i),
        .Y_i         (Y_i),
        .last_i      (last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .P_o         (P_o),
        .count_o     (count_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one beat at the falling edge, let it be taken at the rising edge,
    // then leave the sampling point 1 ns after that edge.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic last);
        @(negedge clk_i);
        in_valid_i = 1'b1;
        X_i        = x;
        Y_i        = y;
        last_i     = last;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        in_valid_i = 1'b0;
        last_i     = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_result(input string tag, input int p, input int cnt, input logic ovf);
        check_eq({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        check_eq({tag, "_P"}, 32'(P_o), 32'(p));
        check_eq({tag, "_count"}, 32'(count_o), 32'(cnt));
        check_eq({tag, "_ovf"}, 32'(ovf_o), 32'(ovf));
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_ready", 32'(in_ready_o), 32'd1);
        check_eq("rst_P", 32'(P_o), 32'd0);
        check_eq("rst_count", 32'(count_o), 32'd0);
        check_eq("rst_ovf", 32'(ovf_o), 32'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;

        // 3*4 + 5*6 + 7*8 = 98
        send(8'd3, 8'd4, 1'b0);
        check_eq("seq1_mid_valid", 32'(out_valid_o), 32'd0);
        send(8'd5, 8'd6, 1'b0);
        send(8'd7, 8'd8, 1'b1);
        check_result("seq1", 98, 3, 1'b0);
        idle_cycle();
        check_eq("seq1_popped", 32'(out_valid_o), 32'd0);
        check_eq("seq1_idle_ready", 32'(in_ready_o), 32'd1);

        // Single beat
        send(8'd255, 8'd255, 1'b1);
        check_result("single", 65025, 1, 1'b0);
        idle_cycle();

        // 17 * 65025 = 1105425 -> 56849 mod 2^20, one wrap on the 17th beat
        for (int i = 0; i < 16; i++) begin
            send(8'd255, 8'd255, 1'b0);
        end
        send(8'd255, 8'd255, 1'b1);
        check_result("wrap", 56849, 17, 1'b1);
        // Popped and next sequence taken in the same cycle; ovf cleared
        send(8'd1, 8'd1, 1'b1);
        check_result("after_wrap", 1, 1, 1'b0);

        // Result pending with back-pressure: beat (2,2,last) held off
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        X_i         = 8'd2;
        Y_i         = 8'd2;
        last_i      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check_eq("bp_ready", 32'(in_ready_o), 32'd0);
            check_eq("bp_valid", 32'(out_valid_o), 32'd1);
            check_eq("bp_P", 32'(P_o), 32'd1);
            check_eq("bp_count", 32'(count_o), 32'd1);
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        check_result("bp_after", 4, 1, 1'b0);
        idle_cycle();

        // Async reset mid-sequence discards the partial sum
        send(8'd10, 8'd10, 1'b0);
        send(8'd10, 8'd10, 1'b0);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        check_eq("arst_P", 32'(P_o), 32'd0);
        check_eq("arst_count", 32'(count_o), 32'd0);
        check_eq("arst_valid", 32'(out_valid_o), 32'd0);
        check_eq("arst_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        send(8'd2, 8'd3, 1'b1);
        check_result("post_rst", 6, 1, 1'b0);
        idle_cycle();

        // Back-to-back single-beat sequences, one result per cycle
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 8'(i), 1'b1);
            check_eq("b2b_ready", 32'(in_ready_o), 32'd1);
            check_result("b2b", i * i, 1, 1'b0);
        end
        idle_cycle();
        check_eq("b2b_end_valid", 32'(out_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
